// File: rtl/cam_sensor_emu.sv
// -----------------------------------------------------------------------------
// cam_sensor_emu
//
// OV-style camera sensor emulator. This block sits at the source end of a
// camera input link. It generates a free-running pixel clock by dividing MCLK.
// It produces frames of VSYNC / HREF / D[7:0] with programmable timing and
// one of four test patterns. Uses: on-board loopback of the capture path, and
// a reusable stimulus source in simulation.
//
// Timing model
//   - One "tick" is one PCLK period, i.e. 2*PCLK_HALF MCLK cycles.
//   - PCLK is low for phases 0..PCLK_HALF-1 and high for the remaining phases.
//   - Phase 0 is the PCLK falling edge. VSYNC/HREF/D change only there, so
//     they are stable when the receiver samples on the PCLK rising edge.
//   - Frame = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT lines.
//     Each line is H_ACTIVE + H_BLANK ticks long.
//
// Ports
//   xipMCLK        in   1   system clock; everything runs from this clock
//   xipRESET       in   1   synchronous reset, active-high
//   xipEN          in   1   1 = frames back to back; 0 = stop after this frame
//   xipMODE        in   2   0 ramp, 1 colour bars, 2 fixed byte, 3 frame count
//   xipFIXED       in   8   byte sent in mode 2
//   xopCAM_PCLK    out  1   pixel clock
//   xopCAM_VSYNC   out  1   frame sync, high for the first VSYNC_LINES lines
//   xopCAM_HREF    out  1   line valid, high for H_ACTIVE ticks of active lines
//   xopCAM_D       out  8   pixel byte, 0 whenever HREF is low
//   xopBUSY        out  1   a frame is in progress
//   xopFRAME_DONE  out  1   one-MCLK pulse on the final tick boundary of a frame
//   xopFRAME_CNT   out 16   completed frames, wraps 0xFFFF -> 0
// -----------------------------------------------------------------------------
module cam_sensor_emu #(
    parameter int PCLK_HALF   = 2,
    parameter int H_ACTIVE    = 640,
    parameter int H_BLANK     = 144,
    parameter int V_ACTIVE    = 240,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10,
    parameter int BAR_W       = 80
) (
    input  logic        xipMCLK,
    input  logic        xipRESET,
    input  logic        xipEN,
    input  logic [1:0]  xipMODE,
    input  logic [7:0]  xipFIXED,
    output logic        xopCAM_PCLK,
    output logic        xopCAM_VSYNC,
    output logic        xopCAM_HREF,
    output logic [7:0]  xopCAM_D,
    output logic        xopBUSY,
    output logic        xopFRAME_DONE,
    output logic [15:0] xopFRAME_CNT
);

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        VFRONT
    } camStateT;

    // Phase counter spans one full PCLK period.
    localparam int              PH_W      = $clog2(2 * PCLK_HALF);
    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(2 * PCLK_HALF - 1);
    localparam logic [PH_W-1:0] PH_HIGH   = PH_W'(PCLK_HALF);

    // Tick and line counters are 12 bits wide. The parameters must fit.
    localparam logic [11:0]     LINE_LAST = 12'(H_ACTIVE + H_BLANK - 1);
    localparam logic [11:0]     H_ACT     = 12'(H_ACTIVE);
    localparam logic [11:0]     VS_LAST   = 12'(VSYNC_LINES - 1);
    localparam logic [11:0]     VB_LAST   = 12'(V_BACK - 1);
    localparam logic [11:0]     VA_LAST   = 12'(V_ACTIVE - 1);
    localparam logic [11:0]     VF_LAST   = 12'(V_FRONT - 1);
    localparam logic [11:0]     BAR_LAST  = 12'(BAR_W - 1);

    // Registered state
    camStateT        state;
    logic [PH_W-1:0] phase;
    logic [11:0]     tickCnt;     // tick index within the current line
    logic [11:0]     lineCnt;     // line index within the current state
    logic [2:0]      barIdx;      // colour bar of the current tick
    logic [11:0]     barSub;      // byte index within the current bar
    logic [1:0]      modeLat;     // pattern mode, held for the whole frame
    logic [7:0]      fixedLat;    // fixed byte, held for the whole frame
    logic [7:0]      cntLat;      // frame count sampled at frame start

    // Next-value logic
    logic [PH_W-1:0] phaseNxt;
    logic            tickEnd;     // this MCLK edge is a tick boundary
    logic            lastTick;
    logic            lastLine;
    logic [11:0]     stateLast;
    logic            frameEnd;
    logic            frameStart;
    camStateT        nxtState;
    logic [11:0]     nxtTick;
    logic [11:0]     nxtLine;
    logic [2:0]      nxtBarIdx;
    logic [11:0]     nxtBarSub;
    logic            nxtHref;
    logic [7:0]      pattern;
    logic [7:0]      nxtD;
    logic [15:0]     cntInc;

    // NOTE: every signal written here gets a default first, so no path through
    // the case/if tree can leave a value unassigned and infer a latch.
    always_comb begin
        tickEnd    = (phase == PH_LAST);
        phaseNxt   = tickEnd ? '0 : phase + PH_W'(1);
        lastTick   = (tickCnt == LINE_LAST);
        cntInc     = xopFRAME_CNT + 16'd1;

        stateLast = 12'd0;
        case (state)
            VSYNC:   stateLast = VS_LAST;
            VBACK:   stateLast = VB_LAST;
            ACTIVE:  stateLast = VA_LAST;
            VFRONT:  stateLast = VF_LAST;
            default: stateLast = 12'd0;
        endcase
        lastLine = (lineCnt == stateLast);

        // The frame ends on the last tick of VFRONT. If there are no front
        // porch lines, it ends on the last tick of ACTIVE.
        frameEnd = lastTick && lastLine &&
                   ((state == VFRONT) || ((state == ACTIVE) && (V_FRONT == 0)));

        // Default: hold. Counters only advance at tick boundaries anyway.
        nxtState = state;
        nxtTick  = tickCnt;
        nxtLine  = lineCnt;

        if (state == IDLE) begin
            if (xipEN) begin
                nxtState = VSYNC;
            end
        end else if (lastTick) begin
            nxtTick = 12'd0;
            if (lastLine) begin
                nxtLine = 12'd0;
                case (state)
                    VSYNC:   nxtState = (V_BACK > 0) ? VBACK : ACTIVE;
                    VBACK:   nxtState = ACTIVE;
                    ACTIVE:  nxtState = (V_FRONT > 0) ? VFRONT
                                                      : (xipEN ? VSYNC : IDLE);
                    VFRONT:  nxtState = xipEN ? VSYNC : IDLE;
                    default: nxtState = IDLE;
                endcase
            end else begin
                nxtLine = lineCnt + 12'd1;
            end
        end else begin
            nxtTick = tickCnt + 12'd1;
        end

        frameStart = xipEN && ((state == IDLE) || frameEnd);

        // Colour-bar tracking. The bar restarts at tick 0 of every line.
        // After that it steps once every BAR_W bytes and saturates at bar 7.
        // This replaces a divide of x by BAR_W.
        nxtBarIdx = barIdx;
        nxtBarSub = barSub;
        if (nxtTick == 12'd0) begin
            nxtBarIdx = 3'd0;
            nxtBarSub = 12'd0;
        end else if (barSub == BAR_LAST) begin
            nxtBarSub = 12'd0;
            nxtBarIdx = (barIdx == 3'd7) ? 3'd7 : barIdx + 3'd1;
        end else begin
            nxtBarSub = barSub + 12'd1;
        end

        // In ACTIVE, lineCnt is the active line index y and tickCnt is the
        // byte index x.
        nxtHref = (nxtState == ACTIVE) && (nxtTick < H_ACT);

        pattern = 8'd0;
        case (modeLat)
            2'd0:    pattern = nxtTick[7:0] + nxtLine[7:0];
            2'd1:    pattern = {nxtBarIdx, 5'b0};
            2'd2:    pattern = fixedLat;
            default: pattern = cntLat;
        endcase
        nxtD = nxtHref ? pattern : 8'd0;
    end

    // NOTE: all state is updated with non-blocking assignments. Every register
    // then sees the pre-edge values of the others, which matches real flops.
    always_ff @(posedge xipMCLK) begin
        if (xipRESET) begin
            state         <= IDLE;
            phase         <= '0;
            tickCnt       <= 12'd0;
            lineCnt       <= 12'd0;
            barIdx        <= 3'd0;
            barSub        <= 12'd0;
            modeLat       <= 2'd0;
            fixedLat      <= 8'd0;
            cntLat        <= 8'd0;
            xopCAM_PCLK   <= 1'b0;
            xopCAM_VSYNC  <= 1'b0;
            xopCAM_HREF   <= 1'b0;
            xopCAM_D      <= 8'd0;
            xopBUSY       <= 1'b0;
            xopFRAME_DONE <= 1'b0;
            xopFRAME_CNT  <= 16'd0;
        end else begin
            phase         <= phaseNxt;
            // PCLK is registered from the next phase, so it falls on the same
            // edge where the video outputs change.
            xopCAM_PCLK   <= (phaseNxt >= PH_HIGH);
            xopFRAME_DONE <= 1'b0;

            if (tickEnd) begin
                state        <= nxtState;
                tickCnt      <= nxtTick;
                lineCnt      <= nxtLine;
                barIdx       <= nxtBarIdx;
                barSub       <= nxtBarSub;
                xopCAM_VSYNC <= (nxtState == VSYNC);
                xopCAM_HREF  <= nxtHref;
                xopCAM_D     <= nxtD;
                xopBUSY      <= (nxtState != IDLE);

                if (frameStart) begin
                    modeLat  <= xipMODE;
                    fixedLat <= xipFIXED;
                    // On a back-to-back start, this frame's count includes
                    // the frame that is completing on this same edge.
                    cntLat   <= frameEnd ? cntInc[7:0] : xopFRAME_CNT[7:0];
                end

                if (frameEnd) begin
                    xopFRAME_DONE <= 1'b1;
                    xopFRAME_CNT  <= cntInc;
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_sensor_emu.sv
// -----------------------------------------------------------------------------
// tb_cam_sensor_emu
//
// Self-checking bench for cam_sensor_emu. It uses the small geometry below:
// 12-tick lines, 8 lines per frame, 96 ticks = 384 MCLK per frame.
// A receiver-style monitor does the following:
//   - captures D on every PCLK rise while HREF is high;
//   - time-stamps VSYNC/HREF edges and FRAME_DONE pulses;
//   - samples on the MCLK falling edge.
// -----------------------------------------------------------------------------
module tb_cam_sensor_emu;

    localparam int FRAME_MCLK = 384;

    logic        xipMCLK;
    logic        xipRESET;
    logic        xipEN;
    logic [1:0]  xipMODE;
    logic [7:0]  xipFIXED;
    logic        xopCAM_PCLK;
    logic        xopCAM_VSYNC;
    logic        xopCAM_HREF;
    logic [7:0]  xopCAM_D;
    logic        xopBUSY;
    logic        xopFRAME_DONE;
    logic [15:0] xopFRAME_CNT;

    cam_sensor_emu #(
        .PCLK_HALF   (2),
        .H_ACTIVE    (8),
        .H_BLANK     (4),
        .V_ACTIVE    (4),
        .VSYNC_LINES (1),
        .V_BACK      (2),
        .V_FRONT     (1),
        .BAR_W       (1)
    ) dut (
        .xipMCLK       (xipMCLK),
        .xipRESET      (xipRESET),
        .xipEN         (xipEN),
        .xipMODE       (xipMODE),
        .xipFIXED      (xipFIXED),
        .xopCAM_PCLK   (xopCAM_PCLK),
        .xopCAM_VSYNC  (xopCAM_VSYNC),
        .xopCAM_HREF   (xopCAM_HREF),
        .xopCAM_D      (xopCAM_D),
        .xopBUSY       (xopBUSY),
        .xopFRAME_DONE (xopFRAME_DONE),
        .xopFRAME_CNT  (xopFRAME_CNT)
    );

    initial xipMCLK = 1'b0;
    always #5 xipMCLK = ~xipMCLK;

    int cyc = 0;
    always @(posedge xipMCLK) cyc <= cyc + 1;

    // Monitor
    logic [7:0] capQ[$];
    int         vsRise[$];
    int         vsFall[$];
    int         hrefRise[$];
    int         doneAt[$];
    logic       prevPclk = 1'b0;
    logic       prevVs   = 1'b0;
    logic       prevHref = 1'b0;

    always @(negedge xipMCLK) begin
        if (xopCAM_PCLK && !prevPclk && xopCAM_HREF) capQ.push_back(xopCAM_D);
        if (xopCAM_VSYNC && !prevVs) vsRise.push_back(cyc);
        if (!xopCAM_VSYNC && prevVs) vsFall.push_back(cyc);
        if (xopCAM_HREF && !prevHref) hrefRise.push_back(cyc);
        if (xopFRAME_DONE) doneAt.push_back(cyc);
        prevPclk <= xopCAM_PCLK;
        prevVs   <= xopCAM_VSYNC;
        prevHref <= xopCAM_HREF;
    end

    // Checking
    int nChecks = 0;
    int nPass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic clearMon();
        capQ.delete();
        vsRise.delete();
        vsFall.delete();
        hrefRise.delete();
        doneAt.delete();
    endtask

    // Eight captured bytes starting at base; the first byte lands in the MSBs.
    function automatic logic [63:0] lineAt(input int base);
        logic [63:0] acc = 64'd0;
        for (int i = 0; i < 8; i++) begin
            acc = {acc[55:0], (base + i < capQ.size()) ? capQ[base + i] : 8'hxx};
        end
        return acc;
    endfunction

    // Count of bytes in frame f (32 per frame) that equal v.
    function automatic int countByte(input int f, input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 32; i++) begin
            if (f * 32 + i < capQ.size() && capQ[f * 32 + i] == v) n++;
        end
        return n;
    endfunction

    task automatic waitVsync(input int limit, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge xipMCLK);
            if (vsRise.size() > 0) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_vsync_timeout"}, 64'(ok), 64'd1);
    endtask

    task automatic waitDone(input int n, input int limit, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge xipMCLK);
            if (doneAt.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_done_timeout"}, 64'(ok), 64'd1);
    endtask

    task automatic pulseReset();
        @(negedge xipMCLK);
        xipRESET = 1'b1;
        repeat (2) @(negedge xipMCLK);
        xipRESET = 1'b0;
    endtask

    // Single-frame vectors
    typedef struct {
        string           name;
        logic [1:0]      mode;
        logic [7:0]      fixed;
        logic [1:0]      midMode;   // applied after VSYNC rises; must not affect this frame
        logic [7:0]      midFixed;
        logic [3:0][63:0] lines;    // expected bursts, y = 0..3
    } vecT;

    localparam logic [63:0] RAMP0 = 64'h0001020304050607;
    localparam logic [63:0] RAMP1 = 64'h0102030405060708;
    localparam logic [63:0] RAMP2 = 64'h0203040506070809;
    localparam logic [63:0] RAMP3 = 64'h030405060708090A;
    localparam logic [63:0] BARS  = 64'h00204060_80A0C0E0;

    vecT vec[5];

    initial begin
        vec[0] = '{name: "ramp",  mode: 2'd0, fixed: 8'h00, midMode: 2'd0, midFixed: 8'h00,
                   lines: {RAMP3, RAMP2, RAMP1, RAMP0}};
        vec[1] = '{name: "bars",  mode: 2'd1, fixed: 8'h00, midMode: 2'd1, midFixed: 8'h00,
                   lines: {BARS, BARS, BARS, BARS}};
        vec[2] = '{name: "fixA5", mode: 2'd2, fixed: 8'hA5, midMode: 2'd2, midFixed: 8'hA5,
                   lines: {4{64'hA5A5A5A5A5A5A5A5}}};
        // Three frames have completed since reset, so the count byte is 03.
        vec[3] = '{name: "count", mode: 2'd3, fixed: 8'h00, midMode: 2'd3, midFixed: 8'h00,
                   lines: {4{64'h0303030303030303}}};
        vec[4] = '{name: "midchg", mode: 2'd0, fixed: 8'h00, midMode: 2'd2, midFixed: 8'hFF,
                   lines: {RAMP3, RAMP2, RAMP1, RAMP0}};

        xipRESET = 1'b1;
        xipEN    = 1'b0;
        xipMODE  = 2'd0;
        xipFIXED = 8'h00;
        repeat (3) @(negedge xipMCLK);

        check("rst_pclk",  64'(xopCAM_PCLK),   64'd0);
        check("rst_vsync", 64'(xopCAM_VSYNC),  64'd0);
        check("rst_href",  64'(xopCAM_HREF),   64'd0);
        check("rst_d",     64'(xopCAM_D),      64'd0);
        check("rst_busy",  64'(xopBUSY),       64'd0);
        check("rst_done",  64'(xopFRAME_DONE), 64'd0);
        check("rst_cnt",   64'(xopFRAME_CNT),  64'd0);

        xipRESET = 1'b0;
        clearMon();
        repeat (40) @(negedge xipMCLK);
        check("idle_no_vsync", 64'(vsRise.size()), 64'd0);
        check("idle_busy",     64'(xopBUSY),       64'd0);

        // One frame per vector. EN drops right after VSYNC rises.
        for (int t = 0; t < 5; t++) begin
            clearMon();
            xipMODE  = vec[t].mode;
            xipFIXED = vec[t].fixed;
            xipEN    = 1'b1;
            waitVsync(20, vec[t].name);
            xipEN = 1'b0;
            repeat (10) @(negedge xipMCLK);
            check({vec[t].name, "_busy_mid"}, 64'(xopBUSY), 64'd1);
            xipMODE  = vec[t].midMode;
            xipFIXED = vec[t].midFixed;
            waitDone(1, FRAME_MCLK + 20, vec[t].name);
            repeat (20) @(negedge xipMCLK);

            check({vec[t].name, "_vs_len"},
                  64'((vsFall.size() > 0 && vsRise.size() > 0) ? vsFall[0] - vsRise[0] : -1), 64'd48);
            check({vec[t].name, "_href_ofs"},
                  64'((hrefRise.size() > 0 && vsRise.size() > 0) ? hrefRise[0] - vsRise[0] : -1), 64'd144);
            check({vec[t].name, "_done_ofs"},
                  64'((doneAt.size() > 0 && vsRise.size() > 0) ? doneAt[0] - vsRise[0] : -1), 64'(FRAME_MCLK));
            check({vec[t].name, "_nbytes"}, 64'(capQ.size()), 64'd32);
            for (int y = 0; y < 4; y++) begin
                check($sformatf("%s_line%0d", vec[t].name, y), lineAt(y * 8), vec[t].lines[y]);
            end
            check({vec[t].name, "_cnt"},      64'(xopFRAME_CNT),   64'(t + 1));
            check({vec[t].name, "_busy_end"}, 64'(xopBUSY),        64'd0);
            check({vec[t].name, "_one_vs"},   64'(vsRise.size()),  64'd1);
            check({vec[t].name, "_one_done"}, 64'(doneAt.size()),  64'd1);
        end

        // PCLK keeps running while idle: 40 MCLK -> 20 toggles.
        begin
            int toggles = 0;
            logic last = xopCAM_PCLK;
            for (int i = 0; i < 40; i++) begin
                @(negedge xipMCLK);
                if (xopCAM_PCLK != last) toggles++;
                last = xopCAM_PCLK;
            end
            check("idle_pclk_toggles", 64'(toggles), 64'd20);
        end

        // Three back-to-back frames in mode 3 straight after reset.
        pulseReset();
        clearMon();
        xipMODE = 2'd3;
        xipEN   = 1'b1;
        waitVsync(20, "b2b");
        waitDone(2, 2 * FRAME_MCLK + 20, "b2b");
        xipEN = 1'b0;
        waitDone(3, FRAME_MCLK + 20, "b2b");
        repeat (20) @(negedge xipMCLK);
        check("b2b_nbytes", 64'(capQ.size()), 64'd96);
        check("b2b_f0", 64'(countByte(0, 8'h00)), 64'd32);
        check("b2b_f1", 64'(countByte(1, 8'h01)), 64'd32);
        check("b2b_f2", 64'(countByte(2, 8'h02)), 64'd32);
        check("b2b_nvs", 64'(vsRise.size()), 64'd3);
        if (vsRise.size() >= 3 && doneAt.size() >= 1) begin
            check("b2b_gap01",   64'(vsRise[1] - vsRise[0]), 64'(FRAME_MCLK));
            check("b2b_gap12",   64'(vsRise[2] - vsRise[1]), 64'(FRAME_MCLK));
            check("b2b_restart", 64'(vsRise[1] - doneAt[0]), 64'd0);
        end
        check("b2b_cnt",  64'(xopFRAME_CNT), 64'd3);
        check("b2b_busy", 64'(xopBUSY),      64'd0);

        // A mode change during frame 1 takes effect in frame 2 only.
        clearMon();
        xipMODE  = 2'd0;
        xipFIXED = 8'h00;
        xipEN    = 1'b1;
        waitVsync(20, "chg");
        repeat (20) @(negedge xipMCLK);
        xipMODE  = 2'd2;
        xipFIXED = 8'hC3;
        waitDone(1, FRAME_MCLK + 20, "chg");
        xipEN = 1'b0;
        waitDone(2, FRAME_MCLK + 20, "chg");
        repeat (10) @(negedge xipMCLK);
        check("chg_f0_line0", lineAt(0),  RAMP0);
        check("chg_f0_line3", lineAt(24), RAMP3);
        check("chg_f1_fixed", 64'(countByte(1, 8'hC3)), 64'd32);
        check("chg_cnt", 64'(xopFRAME_CNT), 64'd5);

        // Reset at tick 50 of a frame, while HREF is high.
        clearMon();
        xipMODE = 2'd0;
        xipEN   = 1'b1;
        waitVsync(20, "rstmid");
        repeat (200) @(negedge xipMCLK);
        check("rstmid_pre_href", 64'(xopCAM_HREF), 64'd1);
        xipRESET = 1'b1;
        @(negedge xipMCLK);
        check("rstmid_pclk",  64'(xopCAM_PCLK),  64'd0);
        check("rstmid_vsync", 64'(xopCAM_VSYNC), 64'd0);
        check("rstmid_href",  64'(xopCAM_HREF),  64'd0);
        check("rstmid_d",     64'(xopCAM_D),     64'd0);
        check("rstmid_busy",  64'(xopBUSY),      64'd0);
        check("rstmid_cnt",   64'(xopFRAME_CNT), 64'd0);
        xipRESET = 1'b0;
        clearMon();
        waitVsync(20, "rstnew");
        xipEN = 1'b0;
        waitDone(1, FRAME_MCLK + 20, "rstnew");
        repeat (10) @(negedge xipMCLK);
        check("rstnew_nbytes", 64'(capQ.size()), 64'd32);
        check("rstnew_line0", lineAt(0),  RAMP0);
        check("rstnew_line1", lineAt(8),  RAMP1);
        check("rstnew_line3", lineAt(24), RAMP3);
        check("rstnew_cnt", 64'(xopFRAME_CNT), 64'd1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/cam_sensor_emu.md
Name: cam_sensor_emu

Overview:
Synthesizable OV-style camera sensor emulator. It is the source end of the camera input interface: it drives PCLK, VSYNC, HREF and D[7:0] with programmable frame timing and test patterns. It is used for on-board loopback of the camera capture path and as a reusable stimulus source in simulation. Runs entirely from MCLK; PCLK is a divided, free-running output.

Parameters:
PCLK_HALF, 2, MCLK cycles per PCLK half-period (>=1); one PCLK period = one "tick"
H_ACTIVE, 640, data bytes per active line (HREF-high ticks), >=1
H_BLANK, 144, HREF-low ticks per line, >=1
V_ACTIVE, 240, active lines per frame, >=1
VSYNC_LINES, 3, lines with VSYNC high at frame start, >=1
V_BACK, 17, blank lines between VSYNC and the first active line
V_FRONT, 10, blank lines after the last active line
BAR_W, 80, bytes per colour bar in mode 1, >=1

Ports:
xipMCLK  in  1  system clock
xipRESET  in  1  synchronous reset, active-high
xipEN  in  1  1 = generate frames continuously; 0 = stop after the current frame
xipMODE  in  2  pattern: 0 ramp, 1 bars, 2 fixed, 3 frame count
xipFIXED  in  8  byte for mode 2
xopCAM_PCLK  out  1  pixel clock
xopCAM_VSYNC  out  1  frame sync, active-high
xopCAM_HREF  out  1  line valid, active-high
xopCAM_D  out  8  pixel byte
xopBUSY  out  1  frame in progress
xopFRAME_DONE  out  1  one-MCLK pulse at frame end
xopFRAME_CNT  out  16  completed frames, wraps 0xFFFF->0

Behaviour:
- Reset: all outputs 0, PCLK low, phase/tick/line counters 0, state IDLE. Applies synchronously at any time, including mid-frame; outputs are 0 on the cycle after reset is sampled.
- Phase counter 0..2*PCLK_HALF-1 is free-running after reset. PCLK = 0 for phases 0..PCLK_HALF-1, 1 for the remaining phases.
- Tick boundary = phase 0, which is the PCLK falling edge. VSYNC, HREF and D change only at tick boundaries. They are stable at the PCLK rising edge, where the receiver samples.
- FSM states: IDLE, VSYNC, VBACK, ACTIVE, VFRONT.
  - IDLE: VSYNC/HREF/D = 0, BUSY = 0. If xipEN = 1, go to VSYNC at the next tick boundary. MODE and FIXED are latched at that boundary and held for the whole frame.
  - VSYNC (VSYNC_LINES lines) -> VBACK (V_BACK lines, skipped if 0) -> ACTIVE (V_ACTIVE lines) -> VFRONT (V_FRONT lines, skipped if 0).
- Line length: H_ACTIVE + H_BLANK ticks. The tick counter wraps at end of line; the line counter advances at that wrap.
- VSYNC = 1 for every tick of the VSYNC lines.
- HREF = 1 during ticks 0..H_ACTIVE-1 of ACTIVE lines only.
- D = 0 whenever HREF = 0. When HREF = 1, with x = byte index 0..H_ACTIVE-1 and y = active line index 0..V_ACTIVE-1:
  - mode 0: D = (x + y) mod 256
  - mode 1: D = {min(x/BAR_W, 7)[2:0], 5'b0}, computed with a per-line bar sub-counter (no divider)
  - mode 2: D = latched FIXED
  - mode 3: D = FRAME_CNT[7:0] as latched at frame start
- Frame end (last tick of the last line):
  - FRAME_DONE pulses on the MCLK cycle of the final tick boundary and FRAME_CNT increments on that same cycle.
  - If EN = 1, the next frame's VSYNC starts in the immediately following tick with no gap; MODE/FIXED are re-latched.
  - Otherwise go to IDLE.
- EN deassertion mid-frame is ignored until frame end; the frame always completes.
- BUSY = 1 from the first VSYNC tick through the final tick of the frame.
- Frame length = (VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT) x (H_ACTIVE + H_BLANK) ticks.
- Counter widths: 12 bits for tick and line counters. Parameter values must fit.

Test Plan:
All scenarios use PCLK_HALF=2, H_ACTIVE=8, H_BLANK=4, V_ACTIVE=4, VSYNC_LINES=1, V_BACK=2, V_FRONT=1, BAR_W=1. Frame = 96 ticks = 384 MCLK.

1. Reset, then EN=1, MODE=0 -> VSYNC high 12 ticks (48 MCLK); HREF first rises 36 ticks after VSYNC rises. Four HREF bursts of 8 bytes: 00..07, 01..08, 02..09, 03..0A. FRAME_DONE after 384 MCLK; FRAME_CNT=1.
2. MODE=1 -> each burst reads 00,20,40,60,80,A0,C0,E0. MODE=2 with FIXED=A5 -> all 32 bytes are A5.
3. EN held, MODE=3, three frames -> bursts carry 00, then 01, then 02. VSYNC of each next frame rises exactly 1 tick after the prior frame's last tick. FRAME_CNT=3.
4. EN dropped at tick 40 of frame 1 -> frame completes; FRAME_DONE pulses once; no further VSYNC; BUSY=0; PCLK keeps toggling.
5. RESET asserted at tick 50 mid-HREF -> next cycle PCLK/VSYNC/HREF/D/BUSY/FRAME_CNT all 0. Release with EN=1 -> a fresh full frame with x, y restarting at 0.
6. MODE changed mid-frame from 0 to 2 -> current frame stays ramp; the next frame is fixed.
